pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter: dataW, default 32, address/data width in bits, minimum 8.
REQ-002 Parameter: RESET_ADDR, default 0, value loaded into ProgAddr on reset.
REQ-003 Parameter: TRAP_ADDR, default 32'h100, misalignment trap handler address.
REQ-004 Port: clock  in  1  single clock, all state updates on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-low reset.
REQ-006 Port: Stall  in  1  high holds ProgAddr; branch and jump requests that cycle are ignored.
REQ-007 Port: EQ, NE, LT, LTU, GE, GEU  in  1 each  branch condition flags.
REQ-008 Port: BranchControl  in  1  conditional branch request.
REQ-009 Port: PCBranchType  in  3  condition select: 0 EQ, 1 NE, 2 LT, 3 LTU, 4 GE, 5 GEU, 6/7 never taken.
REQ-010 Port: JumpControl  in  1  unconditional PC-relative jump (JAL).
REQ-011 Port: JumpReg  in  1  register-indirect jump (JALR).
REQ-012 Port: JumpBase  in  dataW  JALR base register value.
REQ-013 Port: BranchOffset  in  dataW signed  offset for branch/JAL/JALR.
REQ-014 Port: TrapReturn  in  1  return from trap to saved EPC.
REQ-015 Port: Compressed  in  1  current instruction is 16-bit (used only under RVC_EN).
REQ-016 Port: ProgAddr  out  dataW  registered program address.
REQ-017 Port: LinkAddr  out  dataW  combinational ProgAddr + increment (return address).
REQ-018 Port: MisalignTrap  out  1  registered one-cycle trap pulse.
REQ-019 Port: EPC  out  dataW  address of the instruction that trapped.
REQ-020 Port: BadAddr  out  dataW  misaligned target that caused the trap.

Function
REQ-021 FSM states RUN and TRAP; RUN is the reset state.
REQ-022 Increment = 4; arithmetic wraps modulo 2^dataW.
REQ-023 Targets: branch/JAL = ProgAddr + BranchOffset; JALR = (JumpBase + BranchOffset) with bit 0 cleared.
REQ-024 Branch taken = BranchControl and flag selected by PCBranchType.
REQ-025 RUN priority, highest first: TrapReturn (ProgAddr <= EPC + increment), Stall (hold), JumpReg, JumpControl, taken branch, sequential (ProgAddr + increment).
REQ-026 Misaligned target (bits[1:0] != 0): ProgAddr <= TRAP_ADDR, EPC <= ProgAddr, BadAddr <= target, MisalignTrap <= 1, state <= TRAP.
REQ-027 TRAP lasts exactly one cycle: ProgAddr held at TRAP_ADDR, MisalignTrap <= 0, all requests including Stall and TrapReturn ignored, state <= RUN.
REQ-028 Multiple simultaneous requests: only the highest-priority one is acted on.
REQ-029 Sequential increment never traps, even at wrap-around from all-ones.
REQ-030 EPC and BadAddr change only on trap entry.

Reset
REQ-031 reset low at a rising edge: ProgAddr <= RESET_ADDR, EPC <= 0, BadAddr <= 0, MisalignTrap <= 0, state <= RUN.
REQ-032 Reset overrides every input and takes effect in any state, including TRAP.

Configuration
REQ-033 Macro RVC_EN defined: increment is 2 when Compressed is high, otherwise 4; a target traps only if bit 0 is set.
REQ-034 RVC_EN undefined: Compressed ignored, increment always 4, alignment per REQ-026.

Verification
REQ-035 Reset low, then 3 unstalled cycles -> ProgAddr 0, 4, 8, 12.
REQ-036 ProgAddr 0x40, BranchControl=1, PCBranchType=3, LTU=1, offset -16 -> next 0x30; same with PCBranchType=6 -> 0x44.
REQ-037 ProgAddr 0x20, JumpReg=1, JumpBase 0x103, offset 0 -> 0x102 with RVC_EN; without RVC_EN -> trap: ProgAddr 0x100, EPC 0x20, BadAddr 0x102, one-cycle pulse, 0x100 held one cycle, then 0x104.
REQ-038 Stall=1 with JumpControl=1 at 0x80 -> 0x80 held; TrapReturn with EPC 0x20 -> 0x24.
REQ-039 ProgAddr 0xFFFFFFFC sequential -> 0x0, no trap; reset low during TRAP -> RESET_ADDR, RUN, pulse cleared.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter unit: sequential, branch, JAL, JALR and trap-return sequencing with misaligned-target trap.
// Optional macro RVC_EN enables 16-bit compressed increments and halfword-aligned targets.
module pc_unit #(
    parameter int               dataW      = 32,
    parameter logic [dataW-1:0] RESET_ADDR = '0,
    parameter logic [dataW-1:0] TRAP_ADDR  = dataW'(32'h100)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Stall,
    input  logic             EQ,
    input  logic             NE,
    input  logic             LT,
    input  logic             LTU,
    input  logic             GE,
    input  logic             GEU,
    input  logic             BranchControl,
    input  logic [2:0]       PCBranchType,
    input  logic             JumpControl,
    input  logic             JumpReg,
    input  logic [dataW-1:0] JumpBase,
    input  logic [dataW-1:0] BranchOffset,
    input  logic             TrapReturn,
    input  logic             Compressed,
    output logic [dataW-1:0] ProgAddr,
    output logic [dataW-1:0] LinkAddr,
    output logic             MisalignTrap,
    output logic [dataW-1:0] EPC,
    output logic [dataW-1:0] BadAddr
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] TRAP = 1'b1;

    logic [0:0]       state;
    logic [dataW-1:0] incr;
    logic [dataW-1:0] relTarget;
    logic [dataW-1:0] jalrSum;
    logic [dataW-1:0] jalrTarget;
    logic [dataW-1:0] redirTarget;
    logic             redirect;
    logic             branchTaken;
    logic             misaligned;

`ifdef RVC_EN
    assign incr = Compressed ? dataW'(2) : dataW'(4);
`else
    logic unusedCompressed;
    assign unusedCompressed = Compressed;
    assign incr = dataW'(4);
`endif

    assign relTarget  = ProgAddr + BranchOffset;
    assign jalrSum    = JumpBase + BranchOffset;
    assign jalrTarget = {jalrSum[dataW-1:1], 1'b0};
    assign LinkAddr   = ProgAddr + incr;

    always_comb begin
        branchTaken = 1'b0;
        case (PCBranchType)
            3'd0:    branchTaken = EQ;
            3'd1:    branchTaken = NE;
            3'd2:    branchTaken = LT;
            3'd3:    branchTaken = LTU;
            3'd4:    branchTaken = GE;
            3'd5:    branchTaken = GEU;
            default: branchTaken = 1'b0;
        endcase
        branchTaken = branchTaken & BranchControl;
    end

    // Only the highest-priority redirect supplies the target
    always_comb begin
        redirect    = 1'b1;
        redirTarget = relTarget;
        if (JumpReg) begin
            redirTarget = jalrTarget;
        end else if (JumpControl || branchTaken) begin
            redirTarget = relTarget;
        end else begin
            redirect = 1'b0;
        end
    end

`ifdef RVC_EN
    assign misaligned = redirTarget[0];
`else
    assign misaligned = |redirTarget[1:0];
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            ProgAddr     <= RESET_ADDR;
            EPC          <= '0;
            BadAddr      <= '0;
            MisalignTrap <= 1'b0;
            state        <= RUN;
        end else begin
            case (state)
                RUN: begin
                    MisalignTrap <= 1'b0;
                    if (TrapReturn) begin
                        ProgAddr <= EPC + incr;
                    end else if (Stall) begin
                        ProgAddr <= ProgAddr;
                    end else if (redirect && misaligned) begin
                        ProgAddr     <= TRAP_ADDR;
                        EPC          <= ProgAddr;
                        BadAddr      <= redirTarget;
                        MisalignTrap <= 1'b1;
                        state        <= TRAP;
                    end else if (redirect) begin
                        ProgAddr <= redirTarget;
                    end else begin
                        ProgAddr <= ProgAddr + incr;
                    end
                end
                // Trap handler entry is held for exactly one cycle, ignoring all requests
                TRAP: begin
                    MisalignTrap <= 1'b0;
                    state        <= RUN;
                end
                default: begin
                    MisalignTrap <= 1'b0;
                    state        <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: table of per-cycle vectors plus hand-written reset-during-trap sequence.
module tb_pc_unit;

`ifdef RVC_EN
    localparam bit rvc = 1'b1;
`else
    localparam bit rvc = 1'b0;
`endif

    typedef struct {
        logic        stall;
        logic        brCtl;
        logic [2:0]  brType;
        logic [5:0]  flags;
        logic        jal;
        logic        jalr;
        logic [31:0] base;
        logic [31:0] off;
        logic        trapRet;
        logic [31:0] expProg;
        logic        expTrap;
        logic [31:0] expEpc;
        logic [31:0] expBad;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        Stall, EQ, NE, LT, LTU, GE, GEU;
    logic        BranchControl;
    logic [2:0]  PCBranchType;
    logic        JumpControl, JumpReg;
    logic [31:0] JumpBase, BranchOffset;
    logic        TrapReturn, Compressed;
    logic [31:0] ProgAddr, LinkAddr, EPC, BadAddr;
    logic        MisalignTrap;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];
    logic [31:0] epcExp = '0;
    logic [31:0] badExp = '0;

    pc_unit dut (
        .clock(clock), .reset(reset), .Stall(Stall),
        .EQ(EQ), .NE(NE), .LT(LT), .LTU(LTU), .GE(GE), .GEU(GEU),
        .BranchControl(BranchControl), .PCBranchType(PCBranchType),
        .JumpControl(JumpControl), .JumpReg(JumpReg),
        .JumpBase(JumpBase), .BranchOffset(BranchOffset),
        .TrapReturn(TrapReturn), .Compressed(Compressed),
        .ProgAddr(ProgAddr), .LinkAddr(LinkAddr), .MisalignTrap(MisalignTrap),
        .EPC(EPC), .BadAddr(BadAddr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic add(input logic stall, input logic brCtl, input logic [2:0] brType,
                       input logic [5:0] flags, input logic jal, input logic jalr,
                       input logic [31:0] base, input logic [31:0] off, input logic trapRet,
                       input logic [31:0] expProg, input logic expTrap);
        vec_t v;
        v.stall = stall; v.brCtl = brCtl; v.brType = brType; v.flags = flags;
        v.jal = jal; v.jalr = jalr; v.base = base; v.off = off; v.trapRet = trapRet;
        v.expProg = expProg; v.expTrap = expTrap; v.expEpc = epcExp; v.expBad = badExp;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        Stall = v.stall; BranchControl = v.brCtl; PCBranchType = v.brType;
        {GEU, GE, LTU, LT, NE, EQ} = v.flags;
        JumpControl = v.jal; JumpReg = v.jalr; JumpBase = v.base;
        BranchOffset = v.off; TrapReturn = v.trapRet; Compressed = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [31:0] p, input logic t,
                            input logic [31:0] e, input logic [31:0] b);
        checkOutput({tag, " ProgAddr"}, ProgAddr, p);
        checkOutput({tag, " LinkAddr"}, LinkAddr, p + 32'd4);
        checkOutput({tag, " MisalignTrap"}, {31'd0, MisalignTrap}, {31'd0, t});
        checkOutput({tag, " EPC"}, EPC, e);
        checkOutput({tag, " BadAddr"}, BadAddr, b);
    endtask

    initial begin
        vec_t idle;
        idle = '{default: '0};
        idle.expProg = '0;

        // Straight-line, branch-condition, priority and stall vectors
        add(0,0,0,6'b000000,0,0,0,0,0, 32'h4, 0);
        add(0,0,0,6'b000000,0,0,0,0,0, 32'h8, 0);
        add(0,0,0,6'b000000,0,0,0,0,0, 32'hC, 0);
        add(0,0,0,6'b000000,1,0,0,32'h34,0, 32'h40, 0);
        add(0,1,3,6'b001000,0,0,0,-32'd16,0, 32'h30, 0);
        add(0,0,0,6'b000000,1,0,0,32'h10,0, 32'h40, 0);
        add(0,1,6,6'b111111,0,0,0,-32'd16,0, 32'h44, 0);
        add(0,1,0,6'b111110,0,0,0,32'h8,0, 32'h48, 0);
        add(0,1,1,6'b000010,0,0,0,32'h8,0, 32'h50, 0);
        add(0,1,0,6'b111111,1,1,32'h200,0,0, 32'h200, 0);
        add(0,0,0,6'b000000,1,0,0,-32'h180,0, 32'h80, 0);
        add(1,0,0,6'b000000,1,0,0,32'h10,0, 32'h80, 0);
        add(1,0,0,6'b000000,0,1,32'h300,0,0, 32'h80, 0);
        add(0,1,4,6'b010000,0,0,0,32'h4,0, 32'h84, 0);
        add(0,1,5,6'b011111,0,0,0,32'h4,0, 32'h88, 0);
        add(0,1,2,6'b000100,0,0,0,-32'd8,0, 32'h80, 0);
        add(0,1,7,6'b111111,0,0,0,32'h40,0, 32'h84, 0);
        add(0,0,0,6'b000000,1,0,0,-32'h64,0, 32'h20, 0);
        // JALR to 0x102: halfword-aligned target either lands or traps
        if (!rvc) begin epcExp = 32'h20; badExp = 32'h102; end
        add(0,0,0,6'b000000,0,1,32'h103,0,0, rvc ? 32'h102 : 32'h100, !rvc);
        add(1,0,0,6'b000000,1,0,0,32'h40,1, rvc ? 32'h4 : 32'h100, 0);
        add(0,0,0,6'b000000,0,0,0,0,0, rvc ? 32'h8 : 32'h104, 0);
        add(0,0,0,6'b000000,0,0,0,0,1, rvc ? 32'h4 : 32'h24, 0);
        add(0,0,0,6'b000000,0,1,32'hFFFFFFFC,0,0, 32'hFFFFFFFC, 0);
        add(0,0,0,6'b000000,0,0,0,0,0, 32'h0, 0);
        add(0,0,0,6'b000000,0,0,0,0,0, 32'h4, 0);

        applyStimulus(idle);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkAll("reset", 32'h0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge clock);
            #1;
            checkAll($sformatf("vec%0d", i), vecs[i].expProg, vecs[i].expTrap,
                     vecs[i].expEpc, vecs[i].expBad);
        end

        // Odd JAL target traps in every configuration; reset then lands during TRAP
        applyStimulus(idle);
        JumpControl = 1'b1;
        BranchOffset = -32'd3;
        @(posedge clock);
        #1;
        checkAll("oddTrap", 32'h100, 1'b1, 32'h4, 32'h1);
        applyStimulus(idle);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkAll("resetInTrap", 32'h0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkAll("afterReset", 32'h4, 1'b0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
